// File: rtl/mdu_issue_ctrl.sv
// EX-stage issue/commit control for an iterative multiply/divide unit; owns HI/LO.
// Optional: define MDU_BYPASS_EN to forward the MDU result in the cycle it arrives.
module mdu_issue_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [2:0]        ex_op,
    input  logic              ex_sign,
    input  logic [DATA_W-1:0] ex_a,
    input  logic [DATA_W-1:0] ex_b,
    input  logic              reg_stall,
    input  logic              reg_flush,
    output logic              ctl_stall,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              mdu_req_valid,
    input  logic              mdu_req_ready,
    output logic              mdu_req_div,
    output logic              mdu_req_sign,
    output logic [DATA_W-1:0] mdu_req_a,
    output logic [DATA_W-1:0] mdu_req_b,
    input  logic              mdu_resp_valid,
    input  logic [DATA_W-1:0] mdu_resp_hi,
    input  logic [DATA_W-1:0] mdu_resp_lo,
    output logic              mdu_kill
);

    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MFHI = 3'd3;
    localparam logic [2:0] OP_MFLO = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5;
    localparam logic [2:0] OP_MTLO = 3'd6;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

    state_t            state;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              go;
    logic              mt_ok;
    logic              resp_take;

    assign go        = ex_valid & ((ex_op == OP_MUL) | (ex_op == OP_DIV)) & ~reg_flush;
    assign mt_ok     = ex_valid & ~reg_stall & ~reg_flush & (state == StIdle);
    // A flush in the response cycle wins: the result is discarded.
    assign resp_take = (state == StWait) & mdu_resp_valid & ~reg_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            hi_q          <= '0;
            lo_q          <= '0;
            mdu_req_valid <= 1'b0;
            mdu_req_div   <= 1'b0;
            mdu_req_sign  <= 1'b0;
            mdu_req_a     <= '0;
            mdu_req_b     <= '0;
            mdu_kill      <= 1'b0;
        end else begin
            mdu_kill <= 1'b0;
            case (state)
                StIdle: begin
                    if (go) begin
                        state         <= StReq;
                        mdu_req_valid <= 1'b1;
                        mdu_req_div   <= (ex_op == OP_DIV);
                        mdu_req_sign  <= ex_sign;
                        mdu_req_a     <= ex_a;
                        mdu_req_b     <= ex_b;
                    end else if (mt_ok && ex_op == OP_MTHI) begin
                        hi_q <= ex_a;
                    end else if (mt_ok && ex_op == OP_MTLO) begin
                        lo_q <= ex_a;
                    end
                end
                StReq: begin
                    if (reg_flush) begin
                        state         <= StIdle;
                        mdu_req_valid <= 1'b0;
                    end else if (mdu_req_ready) begin
                        state         <= StWait;
                        mdu_req_valid <= 1'b0;
                    end
                end
                StWait: begin
                    if (reg_flush) begin
                        state    <= StIdle;
                        mdu_kill <= 1'b1;
                    end else if (resp_take) begin
                        hi_q <= mdu_resp_hi;
                        lo_q <= mdu_resp_lo;
`ifdef MDU_BYPASS_EN
                        state <= reg_stall ? StDone : StIdle;
`else
                        state <= StDone;
`endif
                    end
                end
                StDone: begin
                    // Holding here while stalled keeps a stalled MUL/DIV from reissuing.
                    if (reg_flush || !reg_stall) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        ctl_stall = 1'b0;
        case (state)
            StIdle:         ctl_stall = go;
            StReq, StWait:  ctl_stall = 1'b1;
            default:        ctl_stall = 1'b0;
        endcase
`ifdef MDU_BYPASS_EN
        if (resp_take) begin
            ctl_stall = 1'b0;
        end
`endif
    end

`ifdef MDU_BYPASS_EN
    assign hi = resp_take ? mdu_resp_hi : hi_q;
    assign lo = resp_take ? mdu_resp_lo : lo_q;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

    always_comb begin
        rd_data = '0;
        if (ex_op == OP_MFHI) begin
            rd_data = hi;
        end else if (ex_op == OP_MFLO) begin
            rd_data = lo;
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: vector table, directed corner cases, random vs model.
module tb_mdu_issue_ctrl;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MFHI = 3'd3;
    localparam logic [2:0] OP_MFLO = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5;
    localparam logic [2:0] OP_MTLO = 3'd6;
`ifdef MDU_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic        ex_sign;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic        reg_stall;
    logic        reg_flush;
    logic        ctl_stall;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mdu_req_valid;
    logic        mdu_req_ready;
    logic        mdu_req_div;
    logic        mdu_req_sign;
    logic [31:0] mdu_req_a;
    logic [31:0] mdu_req_b;
    logic        mdu_resp_valid;
    logic [31:0] mdu_resp_hi;
    logic [31:0] mdu_resp_lo;
    logic        mdu_kill;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_sign(ex_sign),
        .ex_a(ex_a), .ex_b(ex_b), .reg_stall(reg_stall), .reg_flush(reg_flush),
        .ctl_stall(ctl_stall), .rd_data(rd_data), .hi(hi), .lo(lo),
        .mdu_req_valid(mdu_req_valid), .mdu_req_ready(mdu_req_ready),
        .mdu_req_div(mdu_req_div), .mdu_req_sign(mdu_req_sign),
        .mdu_req_a(mdu_req_a), .mdu_req_b(mdu_req_b), .mdu_resp_valid(mdu_resp_valid),
        .mdu_resp_hi(mdu_resp_hi), .mdu_resp_lo(mdu_resp_lo), .mdu_kill(mdu_kill)
    );

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic        stall;
        logic        flush;
        logic [31:0] a;
        logic        exp_ctl;
        logic [31:0] exp_rd;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic of the MDU: {hi, lo}; divide-by-zero yields {a, all-ones}.
    function automatic logic [63:0] mdu_calc(input logic div, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] rm;
        sa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        if (!div) return 64'(sa * sb);
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q  = sa / sb;
        rm = sa % sb;
        return {rm[31:0], q[31:0]};
    endfunction

    // Drives one MUL/DIV through a bench MDU; returns stall cycles and handshake count.
    task automatic run_muldiv(input logic div, input logic sgn, input logic [31:0] a,
                              input logic [31:0] b, input int n, input int rdy_low,
                              output int stalls, output int hs);
        int          acc = -1;
        int          low_left = rdy_low;
        bit          done = 0;
        logic [63:0] res = 64'd0;
        stalls = 0;
        hs = 0;
        ex_valid = 1'b1; ex_op = div ? OP_DIV : OP_MUL; ex_sign = sgn; ex_a = a; ex_b = b;
        for (int c = 0; c < 40 && !done; c++) begin
            mdu_resp_valid = (acc >= 0) && (c == acc + n);
            mdu_resp_hi = res[63:32];
            mdu_resp_lo = res[31:0];
            if (mdu_req_valid && low_left > 0) begin
                mdu_req_ready = 1'b0;
                low_left--;
            end else begin
                mdu_req_ready = 1'b1;
            end
            #1;
            if (ctl_stall) stalls++;
            if (mdu_req_valid) begin
                chk("req_a_stable", mdu_req_a, a);
                chk("req_b_stable", mdu_req_b, b);
                chk_b("req_div", mdu_req_div, div);
                chk_b("req_sign", mdu_req_sign, sgn);
                if (mdu_req_ready) begin
                    hs++;
                    acc = c;
                    res = mdu_calc(mdu_req_div, mdu_req_sign, mdu_req_a, mdu_req_b);
                end
            end
            if (!ctl_stall) done = 1;
            tick();
        end
        chk_b("muldiv_completes", done, 1'b1);
        ex_valid = 1'b0; ex_op = OP_NONE; mdu_resp_valid = 1'b0; mdu_req_ready = 1'b0;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        ex_valid = 1'b1; ex_op = op; ex_a = a;
        tick();
        ex_valid = 1'b0; ex_op = OP_NONE;
    endtask

    initial begin
        int          stalls;
        int          hs;
        int          acc;
        logic [63:0] res;
        logic [31:0] ref_hi;
        logic [31:0] ref_lo;

        vt[0]  = '{1'b1, OP_MTHI, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0};
        vt[1]  = '{1'b1, OP_MFHI, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vt[2]  = '{1'b1, OP_MTLO, 1'b1, 1'b0, 32'h12345678, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0};
        vt[3]  = '{1'b1, OP_MTLO, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0};
        vt[4]  = '{1'b0, OP_MTLO, 1'b0, 1'b0, 32'h12345678, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0};
        vt[5]  = '{1'b1, OP_MTLO, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0, 32'hDEADBEEF,
                   32'hCAFEF00D};
        vt[6]  = '{1'b1, OP_MFLO, 1'b0, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D, 32'hDEADBEEF,
                   32'hCAFEF00D};
        vt[7]  = '{1'b0, OP_MFHI, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF,
                   32'hCAFEF00D};
        vt[8]  = '{1'b1, 3'd7, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 32'hCAFEF00D};
        vt[9]  = '{1'b1, OP_MUL, 1'b0, 1'b1, 32'h5, 1'b0, 32'h0, 32'hDEADBEEF, 32'hCAFEF00D};
        vt[10] = '{1'b0, OP_DIV, 1'b0, 1'b0, 32'h5, 1'b0, 32'h0, 32'hDEADBEEF, 32'hCAFEF00D};
        vt[11] = '{1'b1, OP_NONE, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 32'hCAFEF00D};

        rst = 1'b1; ex_valid = 1'b0; ex_op = OP_NONE; ex_sign = 1'b0; ex_a = '0; ex_b = '0;
        reg_stall = 1'b0; reg_flush = 1'b0; mdu_req_ready = 1'b0; mdu_resp_valid = 1'b0;
        mdu_resp_hi = '0; mdu_resp_lo = '0;
        tick();
        tick();
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk_b("reset_req_valid", mdu_req_valid, 1'b0);
        chk_b("reset_kill", mdu_kill, 1'b0);
        chk("reset_req_a", mdu_req_a, 32'h0);
        chk_b("reset_ctl_stall", ctl_stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single-cycle vectors from IDLE
        for (int i = 0; i < 12; i++) begin
            ex_valid = vt[i].valid; ex_op = vt[i].op; reg_stall = vt[i].stall;
            reg_flush = vt[i].flush; ex_a = vt[i].a; ex_b = 32'd3;
            #1;
            chk_b($sformatf("vec%0d_ctl_stall", i), ctl_stall, vt[i].exp_ctl);
            chk($sformatf("vec%0d_rd_data", i), rd_data, vt[i].exp_rd);
            tick();
            chk($sformatf("vec%0d_hi", i), hi, vt[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), lo, vt[i].exp_lo);
            chk_b($sformatf("vec%0d_req_valid", i), mdu_req_valid, 1'b0);
        end
        ex_valid = 1'b0; ex_op = OP_NONE; reg_stall = 1'b0; reg_flush = 1'b0;
        tick();

        // Signed MUL -2*3, response 4 cycles after acceptance
        run_muldiv(1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, 4, 0, stalls, hs);
        chk("smul_stall_cycles", stalls, 6 - BYP);
        chk("smul_handshakes", hs, 1);
        chk("smul_hi", hi, 32'hFFFFFFFF);
        chk("smul_lo", lo, 32'hFFFFFFFA);

        // Unsigned DIV 100/7 with ready low for 3 REQ cycles
        run_muldiv(1'b1, 1'b0, 32'd100, 32'd7, 3, 3, stalls, hs);
        chk("udiv_stall_cycles", stalls, 3 + 2 + 3 - BYP);
        chk("udiv_handshakes", hs, 1);
        chk("udiv_lo", lo, 32'd14);
        chk("udiv_hi", hi, 32'd2);

        // Flush in WAIT two cycles after acceptance
        mt(OP_MTHI, 32'h11111111);
        mt(OP_MTLO, 32'h22222222);
        ex_valid = 1'b1; ex_op = OP_DIV; ex_sign = 1'b0; ex_a = 32'd50; ex_b = 32'd5;
        mdu_req_ready = 1'b1;
        #1 chk_b("fl_c0_stall", ctl_stall, 1'b1);
        tick();
        chk_b("fl_c1_req_valid", mdu_req_valid, 1'b1);
        tick();
        chk_b("fl_c2_req_valid", mdu_req_valid, 1'b0);
        chk_b("fl_c2_stall", ctl_stall, 1'b1);
        reg_flush = 1'b1; mdu_resp_valid = 1'b1;
        mdu_resp_hi = 32'hAAAAAAAA; mdu_resp_lo = 32'hBBBBBBBB;
        #1;
        chk("fl_c3_hi", hi, 32'h11111111);
        chk_b("fl_c3_kill", mdu_kill, 1'b0);
        tick();
        reg_flush = 1'b0; ex_valid = 1'b0; ex_op = OP_NONE; mdu_resp_valid = 1'b0;
        #1;
        chk_b("fl_c4_kill", mdu_kill, 1'b1);
        chk_b("fl_c4_stall", ctl_stall, 1'b0);
        tick();
        chk_b("fl_c5_kill", mdu_kill, 1'b0);
        mdu_resp_valid = 1'b1;
        tick();
        mdu_resp_valid = 1'b0; mdu_req_ready = 1'b0;
        #1;
        chk("fl_hi_kept", hi, 32'h11111111);
        chk("fl_lo_kept", lo, 32'h22222222);
        chk_b("fl_req_valid", mdu_req_valid, 1'b0);
        chk_b("fl_stall", ctl_stall, 1'b0);
        tick();

        // MUL 5*6 with reg_stall held while the result sits in DONE
        ex_op = OP_MUL; ex_sign = 1'b0; ex_a = 32'd5; ex_b = 32'd6;
        mdu_req_ready = 1'b1; hs = 0; acc = -1; res = 64'd0;
        for (int c = 0; c < 10; c++) begin
            reg_stall = (c >= 3 && c <= 6);
            ex_valid = (c < 8);
            mdu_resp_valid = (acc >= 0) && (c == acc + 2);
            mdu_resp_hi = res[63:32];
            mdu_resp_lo = res[31:0];
            #1;
            if (mdu_req_valid && mdu_req_ready) begin
                hs++;
                acc = c;
                res = mdu_calc(mdu_req_div, mdu_req_sign, mdu_req_a, mdu_req_b);
            end
            if (c >= 4 && c <= 7) begin
                chk_b($sformatf("hold_c%0d_stall", c), ctl_stall, 1'b0);
                chk($sformatf("hold_c%0d_lo", c), lo, 32'd30);
                chk($sformatf("hold_c%0d_hi", c), hi, 32'd0);
            end
            if (c >= 8) chk_b($sformatf("hold_c%0d_req_valid", c), mdu_req_valid, 1'b0);
            tick();
        end
        chk("hold_handshakes", hs, 1);
        ex_valid = 1'b0; ex_op = OP_NONE; reg_stall = 1'b0; mdu_resp_valid = 1'b0;
        mdu_req_ready = 1'b0;

        // Random instruction stream against arithmetic model of HI/LO
        ref_hi = hi;
        ref_lo = lo;
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic        sgn;
            logic        fl;
            int          n;
            int          rl;
            int          ns;
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            sgn = 1'($urandom_range(0, 1));
            if (op == OP_MUL || op == OP_DIV) begin
                n  = int'($urandom_range(1, 5));
                rl = int'($urandom_range(0, 3));
                run_muldiv(op == OP_DIV, sgn, a, b, n, rl, stalls, hs);
                res = mdu_calc(op == OP_DIV, sgn, a, b);
                ref_hi = res[63:32];
                ref_lo = res[31:0];
                chk($sformatf("rnd%0d_stalls", i), stalls, n + 2 - BYP + rl);
                chk($sformatf("rnd%0d_hs", i), hs, 1);
            end else begin
                ns = int'($urandom_range(0, 2));
                fl = ($urandom_range(0, 5) == 0);
                ex_valid = 1'b1; ex_op = op; ex_a = a; ex_b = b;
                for (int s = 0; s <= ns; s++) begin
                    reg_stall = (s < ns);
                    reg_flush = (s == ns) && fl;
                    #1;
                    chk($sformatf("rnd%0d_rd", i), rd_data,
                        (op == OP_MFHI) ? ref_hi : (op == OP_MFLO) ? ref_lo : 32'd0);
                    chk_b($sformatf("rnd%0d_ctl", i), ctl_stall, 1'b0);
                    tick();
                end
                if (!fl && op == OP_MTHI) ref_hi = a;
                if (!fl && op == OP_MTLO) ref_lo = a;
                ex_valid = 1'b0; ex_op = OP_NONE; reg_stall = 1'b0; reg_flush = 1'b0;
            end
            chk($sformatf("rnd%0d_hi", i), hi, ref_hi);
            chk($sformatf("rnd%0d_lo", i), lo, ref_lo);
        end

        // Asynchronous reset while waiting for a response
        mt(OP_MTHI, 32'h0BADF00D);
        ex_valid = 1'b1; ex_op = OP_MUL; ex_sign = 1'b0; ex_a = 32'd7; ex_b = 32'd9;
        mdu_req_ready = 1'b1;
        tick();
        tick();
        #2;
        chk_b("rst_pre_stall", ctl_stall, 1'b1);
        rst = 1'b1; ex_valid = 1'b0; ex_op = OP_NONE;
        #1;
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        chk_b("arst_req_valid", mdu_req_valid, 1'b0);
        chk_b("arst_ctl_stall", ctl_stall, 1'b0);
        chk_b("arst_kill", mdu_kill, 1'b0);
        @(negedge clk);
        rst = 1'b0; mdu_req_ready = 1'b0;
        tick();
        chk_b("post_rst_req_valid", mdu_req_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
